mob_dma: RTL and testbench

MOB_DMA -- requirements
Module: mob_dma

---
 rtl/mob_dma_if.sv | 30 +++
 rtl/mob_dma.sv | 145 ++++++++++++++
 tb/tb_mob_dma.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mob_dma_if.sv
`default_nettype none
// ============================================================================
// Module      : mob_dma_if
// Description : Video-timing, RAM read and MMIO write signals of mob_dma.
// Revision    : 1.0 - initial release
// ============================================================================
interface mob_dma_if;
    logic        vblank;
    logic [15:0] src_base;
    logic        bus_gnt;
    logic [7:0]  mem_data;
    logic        bus_req;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic        we_l;
    logic        busy;

    modport master (
        input  vblank, src_base, bus_gnt, mem_data,
        output bus_req, mem_rd, mem_addr, addr, data_out, we_l, busy
    );

    modport slave (
        output vblank, src_base, bus_gnt, mem_data,
        input  bus_req, mem_rd, mem_addr, addr, data_out, we_l, busy
    );
endinterface
`default_nettype wire

// File: rtl/mob_dma.sv
`default_nettype none
// ============================================================================
// Module      : mob_dma
// Description : Per-frame copy of the motion-object table from RAM into the
//               MMIO register window. Optional done_irq via MOB_DMA_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mob_dma #(
    parameter int          NUM_MOB  = 16,
    parameter logic [15:0] MOB_BASE = 16'h07C0
) (
    input  logic       clk,
    input  logic       rst_l,
    mob_dma_if.master  bus
`ifdef MOB_DMA_IRQ_EN
    ,
    output logic       done_irq
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [5:0] LAST_IDX  = 6'(32 + NUM_MOB - 1);
    localparam logic [3:0] SLOT_LAST = 4'(NUM_MOB - 1);

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [15:0] src_q, src_d;
    logic        vblank_q;
    logic        armed_q;
    logic        start;

    logic        bus_req_c;
    logic        mem_rd_c;
    logic [15:0] mem_addr_c;
    logic [15:0] addr_c;
    logic [7:0]  data_out_c;
    logic        we_l_c;
    logic        busy_c;

    // armed_q masks the first cycle after reset so a vblank already high at
    // release is not mistaken for a fresh edge.
    assign start = bus.vblank & ~vblank_q & armed_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= IDLE;
            idx_q    <= 6'd0;
            src_q    <= 16'h0000;
            vblank_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            src_q    <= src_d;
            vblank_q <= bus.vblank;
            armed_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        src_d      = src_q;
        bus_req_c  = 1'b0;
        mem_rd_c   = 1'b0;
        mem_addr_c = 16'h0000;
        addr_c     = 16'h0000;
        data_out_c = 8'h00;
        we_l_c     = 1'b1;
        busy_c     = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = 6'd0;
                    src_d   = bus.src_base;
                    state_d = REQ;
                end
            end
            REQ: begin
                bus_req_c = 1'b1;
                if (bus.bus_gnt) begin
                    state_d = READ;
                end
            end
            READ: begin
                bus_req_c  = 1'b1;
                mem_rd_c   = 1'b1;
                mem_addr_c = src_q + {10'b0, idx_q};
                state_d    = WRITE;
            end
            WRITE: begin
                bus_req_c  = 1'b1;
                we_l_c     = 1'b0;
                addr_c     = MOB_BASE + {10'b0, idx_q[5:4], 4'b0000} + {12'b0, idx_q[3:0]};
                data_out_c = bus.mem_data;
                if (idx_q == LAST_IDX) begin
                    idx_d   = 6'd0;
                    state_d = IDLE;
                end else begin
                    // Groups are 16-aligned; skip the unused slots when NUM_MOB < 16.
                    if (idx_q[3:0] == SLOT_LAST) begin
                        idx_d = {idx_q[5:4] + 2'd1, 4'b0000};
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                    state_d = bus.bus_gnt ? READ : REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.bus_req  = bus_req_c;
    assign bus.mem_rd   = mem_rd_c;
    assign bus.mem_addr = mem_addr_c;
    assign bus.addr     = addr_c;
    assign bus.data_out = data_out_c;
    assign bus.we_l     = we_l_c;
    assign bus.busy     = busy_c;

`ifdef MOB_DMA_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (state_q == WRITE) && (idx_q == LAST_IDX);
        end
    end

    assign done_irq = irq_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mob_dma.sv
`default_nettype none
// ============================================================================
// Module      : tb_mob_dma
// Description : Directed/randomised bench for mob_dma against a table model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mob_dma;

    logic clk = 1'b0;
    logic rst_l;
    always #5 clk = ~clk;

    mob_dma_if if16 ();
    mob_dma_if if12 ();

`ifdef MOB_DMA_IRQ_EN
    logic irq16, irq12;
`endif

    mob_dma #(.NUM_MOB(16)) dut16 (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (if16.master)
`ifdef MOB_DMA_IRQ_EN
        ,
        .done_irq (irq16)
`endif
    );

    mob_dma #(.NUM_MOB(12)) dut12 (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (if12.master)
`ifdef MOB_DMA_IRQ_EN
        ,
        .done_irq (irq12)
`endif
    );

    logic [7:0] ram [0:65535];

    // RAM returns data the cycle after a sampled read strobe, zero otherwise
    always @(posedge clk) begin
        if16.mem_data <= if16.mem_rd ? ram[if16.mem_addr] : 8'h00;
        if12.mem_data <= if12.mem_rd ? ram[if12.mem_addr] : 8'h00;
    end

    int tests = 0;
    int fails = 0;
    logic sel12 = 1'b0;

    logic        s_we, s_rd, s_busy, s_req, s_irq;
    logic [15:0] s_addr, s_maddr;
    logic [7:0]  s_data;

    always_comb begin
        s_we    = sel12 ? if12.we_l     : if16.we_l;
        s_rd    = sel12 ? if12.mem_rd   : if16.mem_rd;
        s_busy  = sel12 ? if12.busy     : if16.busy;
        s_req   = sel12 ? if12.bus_req  : if16.bus_req;
        s_addr  = sel12 ? if12.addr     : if16.addr;
        s_maddr = sel12 ? if12.mem_addr : if16.mem_addr;
        s_data  = sel12 ? if12.data_out : if16.data_out;
`ifdef MOB_DMA_IRQ_EN
        s_irq   = sel12 ? irq12 : irq16;
`else
        s_irq   = 1'b0;
`endif
    end

    logic [15:0] got_wa[$], got_ra[$], exp_wa[$], exp_ra[$];
    logic [7:0]  got_wd[$], exp_wd[$];
    int busy_cyc, act_cyc, irq_cyc, irq_ok;
    logic prev_last = 1'b0;
    logic [15:0] last_addr = 16'h07EF;

    always @(negedge clk) begin
        if (rst_l) begin
            if (!s_we) begin
                got_wa.push_back(s_addr);
                got_wd.push_back(s_data);
            end
            if (s_rd) got_ra.push_back(s_maddr);
            if (s_busy) busy_cyc++;
            if (s_rd || !s_we) act_cyc++;
            if (s_irq) begin
                irq_cyc++;
                if (prev_last) irq_ok++;
            end
            prev_last = !s_we && (s_addr == last_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: slot s of group g lands at window offset 16*g+s and is read
    // from table offset 16*g+s.
    task automatic build_exp(input int n, input logic [15:0] src);
        logic [15:0] off;
        exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
        for (int g = 0; g < 3; g++) begin
            for (int s = 0; s < n; s++) begin
                off = 16'(16 * g + s);
                exp_wa.push_back(16'h07C0 + off);
                exp_ra.push_back(src + off);
                exp_wd.push_back(ram[src + off]);
            end
        end
    endtask

    task automatic clear_obs;
        got_wa.delete(); got_wd.delete(); got_ra.delete();
        busy_cyc = 0; act_cyc = 0; irq_cyc = 0; irq_ok = 0;
    endtask

    task automatic check_lists(input string tag);
        int nmis;
        nmis = 0;
        check({tag, "_nwr"}, 32'(got_wa.size()), 32'(exp_wa.size()));
        check({tag, "_nrd"}, 32'(got_ra.size()), 32'(exp_ra.size()));
        for (int i = 0; i < got_wa.size() && i < exp_wa.size(); i++)
            if (got_wa[i] !== exp_wa[i] || got_wd[i] !== exp_wd[i]) nmis++;
        for (int i = 0; i < got_ra.size() && i < exp_ra.size(); i++)
            if (got_ra[i] !== exp_ra[i]) nmis++;
        check({tag, "_mismatches"}, 32'(nmis), 32'd0);
    endtask

    task automatic pulse_vblank;
        if (sel12) if12.vblank = 1'b1; else if16.vblank = 1'b1;
        tick;
        if (sel12) if12.vblank = 1'b0; else if16.vblank = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (s_busy && n < max_cyc) begin
            tick;
            n++;
        end
        check({tag, "_done"}, 32'(s_busy), 32'd0);
    endtask

    task automatic wait_write(input string tag, input logic [15:0] a);
        int n;
        n = 0;
        while (!(s_we == 1'b0 && s_addr == a) && n < 400) begin
            tick;
            n++;
        end
        check({tag, "_reach"}, {16'h0, s_addr}, {16'h0, a});
    endtask

    initial begin
        int hold, bcnt, bad;
        logic [15:0] src;

        rst_l = 1'b0;
        if16.vblank = 1'b0; if16.src_base = 16'h0; if16.bus_gnt = 1'b0;
        if12.vblank = 1'b0; if12.src_base = 16'h0; if12.bus_gnt = 1'b0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        for (int k = 0; k < 48; k++) ram[16'h0400 + k] = 8'(k);
        clear_obs();
        tick; tick;

        // reset state
        check("rst_busy",    32'(if16.busy),     32'd0);
        check("rst_we_l",    32'(if16.we_l),     32'd1);
        check("rst_bus_req", 32'(if16.bus_req),  32'd0);
        check("rst_mem_rd",  32'(if16.mem_rd),   32'd0);
        check("rst_addr",    32'(if16.addr),     32'd0);
        check("rst_maddr",   32'(if16.mem_addr), 32'd0);
        check("rst_data",    32'(if16.data_out), 32'd0);
        check("rst_busy12",  32'(if12.busy),     32'd0);
        rst_l = 1'b1;
        tick; tick; tick;

        // T1: identity table, continuous grant
        if16.src_base = 16'h0400;
        if16.bus_gnt  = 1'b1;
        build_exp(16, 16'h0400);
        clear_obs();
        pulse_vblank();
        wait_idle("t1", 300);
        check_lists("t1");
        check("t1_first_addr", 32'(got_wa[0]),  32'h07C0);
        check("t1_last_addr",  32'(got_wa[47]), 32'h07EF);
        check("t1_last_data",  32'(got_wd[47]), 32'h2F);
        check("t1_busy_cyc",   32'(busy_cyc),   32'd97);
        check("t1_act_cyc",    32'(act_cyc),    32'd96);
`ifdef MOB_DMA_IRQ_EN
        check("t1_irq_cyc", 32'(irq_cyc), 32'd1);
        check("t1_irq_pos", 32'(irq_ok),  32'd1);
`endif
        tick; tick;

        // T2: grant withdrawn for 5 cycles after write to 07C5
        src = 16'($urandom);
        if16.src_base = src;
        build_exp(16, src);
        clear_obs();
        pulse_vblank();
        wait_write("t2", 16'h07C5);
        if16.bus_gnt = 1'b0;
        hold = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (if16.bus_req && !if16.mem_rd && if16.we_l && if16.busy) hold++;
        end
        if16.bus_gnt = 1'b1;
        check("t2_hold_req", 32'(hold), 32'd5);
        wait_idle("t2", 300);
        check_lists("t2");
        check("t2_resume_addr", 32'(got_wa[6]), 32'h07C6);
        check("t2_resume_data", 32'(got_wd[6]), 32'(exp_wd[6]));
        check("t2_busy_cyc",    32'(busy_cyc),  32'd102);
        tick; tick;

        // T3: second vblank edge mid-copy and src_base change are ignored
        src = 16'($urandom);
        if16.src_base = src;
        build_exp(16, src);
        clear_obs();
        pulse_vblank();
        bcnt = 0;
        while (got_wa.size() < 20 && bcnt < 200) begin
            tick;
            bcnt++;
        end
        if16.src_base = 16'($urandom);
        pulse_vblank();
        wait_idle("t3", 300);
        for (int i = 0; i < 10; i++) tick;
        check_lists("t3");
        check("t3_still_idle", 32'(if16.busy), 32'd0);
        tick; tick;

        // T4: reset mid-copy aborts; vblank high across release does not start
        src = 16'($urandom);
        if16.src_base = src;
        clear_obs();
        pulse_vblank();
        wait_write("t4", 16'h07D3);
        tick;
        rst_l = 1'b0;
        #1;
        check("t4_rst_we_l",  32'(if16.we_l),    32'd1);
        check("t4_rst_busy",  32'(if16.busy),    32'd0);
        check("t4_rst_req",   32'(if16.bus_req), 32'd0);
        check("t4_nwr_abort", 32'(got_wa.size()), 32'd20);
        if16.vblank = 1'b1;
        tick; tick;
        rst_l = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (if16.busy) bcnt++;
        end
        check("t4_no_spurious", 32'(bcnt), 32'd0);
        if16.vblank = 1'b0;
        tick;
        build_exp(16, src);
        clear_obs();
        pulse_vblank();
        wait_idle("t4", 300);
        check_lists("t4");
        check("t4_restart_addr", 32'(got_wa[0]), 32'h07C0);
        tick; tick;

        // T5: NUM_MOB=12 under a random grant pattern
        sel12 = 1'b1;
        last_addr = 16'h07EB;
        src = 16'($urandom);
        if12.src_base = src;
        if12.bus_gnt  = 1'b1;
        build_exp(12, src);
        tick;
        clear_obs();
        pulse_vblank();
        bcnt = 0;
        while (if12.busy && bcnt < 2000) begin
            if12.bus_gnt = ($urandom_range(0, 3) != 0);
            tick;
            bcnt++;
        end
        if12.bus_gnt = 1'b1;
        wait_idle("t5", 300);
        check_lists("t5");
        bad = 0;
        foreach (got_wa[i])
            if (got_wa[i] >= 16'h07CC && got_wa[i] <= 16'h07CF) bad++;
        check("t5_gap_writes", 32'(bad),     32'd0);
        check("t5_act_cyc",    32'(act_cyc), 32'd72);
`ifdef MOB_DMA_IRQ_EN
        check("t5_irq_cyc", 32'(irq_cyc), 32'd1);
        check("t5_irq_pos", 32'(irq_ok),  32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
